rr_request_agent: RTL and testbench
===================================

// Module: rr_request_agent
// PURPOSE
//  Requester-side partner of the weighted round-robin arbiter datapath. Holds
//  queued jobs (channel, burst length) for 8 clients and drives request[7:0]
//  and the packed weight[31:0] into the arbiter. Consumes its one-hot grant[7:0],
//  counts served cycles per job, retires each job and reports completion.
// PARAMETERS
//  NCH    8  number of client channels (request/grant width)
//  LW     4  burst-length field width; weight width = NCH*LW = 32
//  DEPTH  4  per-channel job queue depth (power of 2)
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   asynchronous, active-low reset
//  push_valid   in   1   job offered this cycle
//  push_ready   out  1   selected channel queue not full
//  push_ch      in   3   target channel of offered job
//  push_len     in   4   burst length in grant cycles; 0 is treated as 1
//  grant        in   8   arbiter grant, expected one-hot or zero
//  request      out  8   request[i]=1 while channel i queue non-empty
//  weight       out  32  weight[i*4+:4] = head-job length of channel i (0 if empty)
//  done_valid   out  1   one-cycle pulse: a job retired
//  done_ch      out  3   channel of retired job, valid with done_valid
//  busy         out  1   OR of request
//  err_grant    out  1   sticky: multi-hot grant, or grant to non-requesting ch
// BEHAVIOUR
//  - Reset (reset==0, async): all queues empty, counters 0, every channel IDLE;
//    request=0, weight=0, done_valid=0, done_ch=0, busy=0, err_grant=0.
//  - Push: accepted on posedge when push_valid && push_ready. push_ready is
//    combinational from registered occupancy of push_ch; no full-bypass, so a
//    full channel refuses a push even if it pops in the same cycle.
//  - Latency: job accepted at edge N -> request/weight reflect it after edge N.
//  - Per-channel FSM: IDLE (empty) -> PEND on push; PEND -> SERV on first
//    grant cycle; SERV -> PEND (next job queued) or IDLE (queue empty) on the
//    retiring cycle. Grant removed mid-burst: stay SERV, counter holds
//    (preemption legal, service resumes on next grant).
//  - Service: a cycle with grant[i]&&request[i] increments cnt_i (width LW).
//    When cnt_i+1 == eff_len (eff_len = len==0 ? 1 : len) the head job pops,
//    cnt_i clears, and done_valid/done_ch are registered from that cycle, i.e.
//    pulse in the following cycle. Max length 15 -> 15 grant cycles.
//  - request[i] falls the cycle after the retiring grant if queue becomes
//    empty; otherwise stays high and weight slice updates to next head.
//  - Multi-hot grant: serve lowest-index set bit that is requesting only; set
//    err_grant. Grant to non-requesting channel: ignored, set err_grant.
//    err_grant clears only on reset.
//  - Simultaneous push and retire on same non-full channel: both take effect;
//    occupancy unchanged; FIFO order preserved.
//  - Zero grant: no state change except pushes.
//  - Reset mid-burst: job lost, no done pulse, all outputs to reset values.
// STRUCTURE
//  - Shared package rr_pkg: NCH, LW, CH_W=$clog2(NCH), DEPTH, channel state
//    encodings IDLE/PEND/SERV, eff_len function.
//  - Sub-module rr_len_fifo (LW wide, DEPTH deep, count/full/empty, async
//    active-low reset), instantiated NCH times in a generate loop; top holds
//    per-channel FSM, counters, grant decode and done register.
// TESTING
//  1 Reset: drive reset=0 mid-burst (ch2 len 5, 3 served) -> all outputs 0
//    immediately; after release, ch2 request=0, no done pulse.
//  2 Push ch3 len 4, grant=8'h08 held -> request=8'h08, weight[15:12]=4 next
//    cycle; 4 grant cycles; done_valid=1, done_ch=3 one cycle after 4th; then
//    request=0.
//  3 Fill ch0 with 4 jobs (len 1,2,3,0) -> push_ready=0 on 5th push; grant ch0
//    continuously -> done pulses after 1,2,3,1 cycles, weight[3:0] steps 1,2,3,0.
//  4 Preemption: ch1 len 6, grant 2 cycles, grant=0 for 3, grant 4 more ->
//    exactly one done after total 6 grant cycles, request held throughout.
//  5 grant=8'h05 with ch0,ch2 requesting -> only ch0 counts, err_grant=1
//    sticky; grant=8'h80 with ch7 empty -> ignored, no state change.
//  6 ch5 holding 2 jobs, push ch5 on retiring cycle -> accepted, occupancy
//    stays 2, order kept; full ch5 retiring + push -> push refused.

Source files
------------

// File: rtl/rr_pkg.sv
// Shared constants, channel state encoding and burst-length helper for the
// round-robin request agent.
package rr_pkg;

    localparam int unsigned NCH   = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned CH_W  = $clog2(NCH);
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Per-channel job state: empty, waiting for a grant, burst in progress.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SERV = 2'd2
    } ch_state_e;

    // A zero-length job still occupies one grant cycle.
    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
        return (len == '0) ? LW'(1) : len;
    endfunction

endpackage

// File: rtl/rr_len_fifo.sv
// Small per-channel job queue holding burst lengths; exposes the head entry,
// occupancy and full/empty flags. Pushes when full and pops when empty are
// ignored.
module rr_len_fifo
    import rr_pkg::*;
#(
    parameter int unsigned W = LW,
    parameter int unsigned D = DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [W-1:0]          din_i,
    input  logic                  pop_i,
    output logic [W-1:0]          head_o,
    output logic [$clog2(D):0]    count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int unsigned AW = $clog2(D);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(D);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [W-1:0]  mem_q [D];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Storage, pointers and occupancy; pointers wrap naturally (D is a power of 2).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < D; k++) begin
                mem_q[k] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/rr_request_agent.sv
// Requester side of the weighted round-robin arbiter: queues jobs per client,
// presents request/weight, counts granted cycles per head job, retires jobs
// and reports completion one cycle after the retiring grant.
module rr_request_agent
    import rr_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                push_valid,
    output logic                push_ready,
    input  logic [CH_W-1:0]     push_ch,
    input  logic [LW-1:0]       push_len,
    input  logic [NCH-1:0]      grant,
    output logic [NCH-1:0]      request,
    output logic [NCH*LW-1:0]   weight,
    output logic                done_valid,
    output logic [CH_W-1:0]     done_ch,
    output logic                busy,
    output logic                err_grant
);

    localparam logic [LW-1:0]    CNT_ONE = LW'(1);
    localparam logic [CNT_W-1:0] OCC_ONE = CNT_W'(1);
    localparam logic [NCH-1:0]   VEC_ONE = NCH'(1);

    ch_state_e        state_q [NCH];
    ch_state_e        state_d [NCH];
    logic [LW-1:0]    cnt_q   [NCH];
    logic [LW-1:0]    cnt_d   [NCH];
    logic [LW-1:0]    head    [NCH];
    logic [CNT_W-1:0] occ     [NCH];
    logic [NCH-1:0]   full;
    logic [NCH-1:0]   empty;
    logic [NCH-1:0]   fifo_push;
    logic [NCH-1:0]   serve;
    logic [NCH-1:0]   retire;
    logic             done_valid_q, done_valid_d;
    logic [CH_W-1:0]  done_ch_q, done_ch_d;
    logic             err_q, err_d;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        rr_len_fifo #(
            .W (LW),
            .D (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (reset),
            .push_i  (fifo_push[g]),
            .din_i   (push_len),
            .pop_i   (retire[g]),
            .head_o  (head[g]),
            .count_o (occ[g]),
            .full_o  (full[g]),
            .empty_o (empty[g])
        );

        assign request[g]           = (state_q[g] != IDLE);
        assign weight[g*LW +: LW]   = empty[g] ? '0 : head[g];
    end

    assign push_ready = !full[push_ch];
    assign busy       = |request;
    assign done_valid = done_valid_q;
    assign done_ch    = done_ch_q;
    assign err_grant  = err_q;

    // Grant decode: serve the lowest-index granted channel that is requesting;
    // flag multi-hot grants and grants to idle channels.
    always_comb begin
        logic found;
        serve = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && grant[i] && request[i]) begin
                serve[i] = 1'b1;
                found    = 1'b1;
            end
        end
        err_d = err_q
              | (|(grant & (grant - VEC_ONE)))
              | (|(grant & ~request));
    end

    // Per-channel next state, service counter, queue push/pop and done capture.
    always_comb begin
        done_valid_d = 1'b0;
        done_ch_d    = done_ch_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            fifo_push[i] = push_valid && push_ready && (push_ch == CH_W'(i));
            retire[i]    = serve[i] && ((cnt_q[i] + CNT_ONE) == eff_len(head[i]));
            state_d[i]   = state_q[i];
            cnt_d[i]     = cnt_q[i];

            if (retire[i]) begin
                cnt_d[i]     = '0;
                done_valid_d = 1'b1;
                done_ch_d    = CH_W'(i);
            end else if (serve[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end

            case (state_q[i])
                IDLE: begin
                    if (fifo_push[i]) state_d[i] = PEND;
                end
                PEND, SERV: begin
                    if (retire[i]) begin
                        state_d[i] = ((occ[i] == OCC_ONE) && !fifo_push[i]) ? IDLE : PEND;
                    end else if (serve[i]) begin
                        state_d[i] = SERV;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // State, counter, done and sticky error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            done_valid_q <= 1'b0;
            done_ch_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            done_valid_q <= done_valid_d;
            done_ch_q    <= done_ch_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_rr_request_agent.sv
// Self-checking bench for rr_request_agent: scenario tasks with inline checks,
// plus a scoreboard of expected done channels drained by a done monitor.
module tb_rr_request_agent;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic        push_ready;
    logic [2:0]  push_ch;
    logic [3:0]  push_len;
    logic [7:0]  grant;
    logic [7:0]  request;
    logic [31:0] weight;
    logic        done_valid;
    logic [2:0]  done_ch;
    logic        busy;
    logic        err_grant;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    logic [2:0]  sb [$];

    always #5 clk = ~clk;

    rr_request_agent dut (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_ch    (push_ch),
        .push_len   (push_len),
        .grant      (grant),
        .request    (request),
        .weight     (weight),
        .done_valid (done_valid),
        .done_ch    (done_ch),
        .busy       (busy),
        .err_grant  (err_grant)
    );

    task automatic do_push(input logic [2:0] ch, input logic [3:0] len);
        push_valid = 1'b1;
        push_ch    = ch;
        push_len   = len;
        @(negedge clk);
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (request !== 8'h00) $display("FAIL rst_req got %h exp 00", request); else n_pass++;
        n_total++; if (weight !== 32'h0) $display("FAIL rst_weight got %h exp 0", weight); else n_pass++;
        n_total++; if ({done_valid, done_ch, busy, err_grant} !== 6'b0) $display("FAIL rst_flags got %b exp 000000", {done_valid, done_ch, busy, err_grant}); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        // ch2 len 5, three cycles served, then reset mid-burst
        do_push(3'd2, 4'd5);
        grant = 8'h04;
        repeat (3) @(negedge clk);
        grant = 8'h00;
        #2 reset = 1'b0;
        #1;
        n_total++; if (request !== 8'h00) $display("FAIL midrst_req got %h exp 00", request); else n_pass++;
        n_total++; if (weight !== 32'h0) $display("FAIL midrst_weight got %h exp 0", weight); else n_pass++;
        n_total++; if ({done_valid, busy, err_grant} !== 3'b0) $display("FAIL midrst_flags got %b exp 000", {done_valid, busy, err_grant}); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (request[2] !== 1'b0) $display("FAIL postrst_req2 got %b exp 0", request[2]); else n_pass++;
        n_total++; if (done_valid !== 1'b0) $display("FAIL postrst_done got %b exp 0", done_valid); else n_pass++;
    endtask

    task automatic test_single_job();
        do_push(3'd3, 4'd4);
        n_total++; if (request !== 8'h08) $display("FAIL t2_req got %h exp 08", request); else n_pass++;
        n_total++; if (weight[15:12] !== 4'd4) $display("FAIL t2_weight got %h exp 4", weight[15:12]); else n_pass++;
        grant = 8'h08;
        for (int c = 1; c <= 4; c++) begin
            if (c < 4) begin
                @(negedge clk);
                n_total++; if (done_valid !== 1'b0) $display("FAIL t2_early_done cyc %0d got %b exp 0", c, done_valid); else n_pass++;
            end else begin
                sb.push_back(3'd3);
                @(negedge clk);
            end
        end
        grant = 8'h00;
        n_total++; if (done_valid !== 1'b1 || done_ch !== 3'd3) $display("FAIL t2_done got %b/%0d exp 1/3", done_valid, done_ch); else n_pass++;
        n_total++; if (request !== 8'h00) $display("FAIL t2_req_after got %h exp 00", request); else n_pass++;
        @(negedge clk);
        n_total++; if (done_valid !== 1'b0) $display("FAIL t2_pulse_width got %b exp 0", done_valid); else n_pass++;
        n_total++; if (err_grant !== 1'b0) $display("FAIL t2_err got %b exp 0", err_grant); else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic [3:0] exp_w [7] = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd0, 4'd0};
        logic       exp_d [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_push(3'd0, 4'd1);
        do_push(3'd0, 4'd2);
        do_push(3'd0, 4'd3);
        do_push(3'd0, 4'd0);
        push_valid = 1'b1; push_ch = 3'd0; push_len = 4'd7;
        #1;
        n_total++; if (push_ready !== 1'b0) $display("FAIL t3_full_ready got %b exp 0", push_ready); else n_pass++;
        @(negedge clk);
        push_valid = 1'b0;
        n_total++; if (weight[3:0] !== 4'd1) $display("FAIL t3_head got %h exp 1", weight[3:0]); else n_pass++;
        grant = 8'h01;
        for (int c = 0; c < 7; c++) begin
            if (exp_d[c]) sb.push_back(3'd0);
            @(negedge clk);
            n_total++; if (weight[3:0] !== exp_w[c]) $display("FAIL t3_weight cyc %0d got %h exp %h", c + 1, weight[3:0], exp_w[c]); else n_pass++;
            n_total++; if (done_valid !== exp_d[c]) $display("FAIL t3_done cyc %0d got %b exp %b", c + 1, done_valid, exp_d[c]); else n_pass++;
            if (c == 0) begin
                n_total++; if (push_ready !== 1'b1) $display("FAIL t3_ready_after_pop got %b exp 1", push_ready); else n_pass++;
            end
        end
        grant = 8'h00;
        n_total++; if (request !== 8'h00) $display("FAIL t3_req_after got %h exp 00", request); else n_pass++;
    endtask

    task automatic test_preempt();
        do_push(3'd1, 4'd6);
        grant = 8'h02;
        repeat (2) @(negedge clk);
        grant = 8'h00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++; if (request !== 8'h02) $display("FAIL t4_req_held cyc %0d got %h exp 02", c, request); else n_pass++;
            n_total++; if (done_valid !== 1'b0) $display("FAIL t4_no_done cyc %0d got %b exp 0", c, done_valid); else n_pass++;
        end
        grant = 8'h02;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) sb.push_back(3'd1);
            @(negedge clk);
            n_total++; if (done_valid !== (c == 4)) $display("FAIL t4_done cyc %0d got %b exp %b", c, done_valid, c == 4); else n_pass++;
        end
        grant = 8'h00;
        n_total++; if (request !== 8'h00) $display("FAIL t4_req_after got %h exp 00", request); else n_pass++;
    endtask

    task automatic test_bad_grant();
        do_push(3'd0, 4'd3);
        do_push(3'd2, 4'd3);
        grant = 8'h05;
        @(negedge clk);
        grant = 8'h80;
        n_total++; if (err_grant !== 1'b1) $display("FAIL t5_err_multi got %b exp 1", err_grant); else n_pass++;
        @(negedge clk);
        n_total++; if (request !== 8'h05) $display("FAIL t5_req_stray got %h exp 05", request); else n_pass++;
        // ch2 must still need all 3 cycles
        grant = 8'h04;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) sb.push_back(3'd2);
            @(negedge clk);
        end
        n_total++; if (request !== 8'h01) $display("FAIL t5_req_ch2_done got %h exp 01", request); else n_pass++;
        // ch0 kept its one served cycle: two more finish it
        grant = 8'h01;
        @(negedge clk);
        n_total++; if (request !== 8'h01) $display("FAIL t5_ch0_mid got %h exp 01", request); else n_pass++;
        sb.push_back(3'd0);
        @(negedge clk);
        grant = 8'h00;
        n_total++; if (request !== 8'h00) $display("FAIL t5_req_after got %h exp 00", request); else n_pass++;
        n_total++; if (err_grant !== 1'b1) $display("FAIL t5_err_sticky got %b exp 1", err_grant); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_push(3'd5, 4'd2);
        do_push(3'd5, 4'd3);
        grant = 8'h20;
        @(negedge clk);
        push_valid = 1'b1; push_ch = 3'd5; push_len = 4'd1;
        #1;
        n_total++; if (push_ready !== 1'b1) $display("FAIL t6_ready got %b exp 1", push_ready); else n_pass++;
        sb.push_back(3'd5);
        @(negedge clk);
        push_valid = 1'b0;
        n_total++; if (weight[23:20] !== 4'd3) $display("FAIL t6_order_head got %h exp 3", weight[23:20]); else n_pass++;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) sb.push_back(3'd5);
            @(negedge clk);
        end
        grant = 8'h00;
        n_total++; if (weight[23:20] !== 4'd1) $display("FAIL t6_pushed_head got %h exp 1", weight[23:20]); else n_pass++;
        do_push(3'd5, 4'd2);
        do_push(3'd5, 4'd2);
        do_push(3'd5, 4'd2);
        // full queue retiring its head: the same-cycle push is refused
        push_valid = 1'b1; push_ch = 3'd5; push_len = 4'd9;
        grant = 8'h20;
        #1;
        n_total++; if (push_ready !== 1'b0) $display("FAIL t6_full_ready got %b exp 0", push_ready); else n_pass++;
        sb.push_back(3'd5);
        @(negedge clk);
        push_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c % 2 == 0) sb.push_back(3'd5);
            @(negedge clk);
        end
        grant = 8'h00;
        n_total++; if (request[5] !== 1'b0) $display("FAIL t6_refused_push got %b exp 0", request[5]); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL t6_busy got %b exp 0", busy); else n_pass++;
    endtask

    initial begin
        reset      = 1'b0;
        push_valid = 1'b0;
        push_ch    = 3'd0;
        push_len   = 4'd0;
        grant      = 8'h00;
        fork
            forever begin
                @(negedge clk);
                if (done_valid === 1'b1) begin
                    n_total++;
                    if (sb.size() == 0) begin
                        $display("FAIL sb_unexpected_done got ch %0d exp none", done_ch);
                    end else begin
                        logic [2:0] exp_ch;
                        exp_ch = sb.pop_front();
                        if (done_ch !== exp_ch) $display("FAIL sb_done_ch got %0d exp %0d", done_ch, exp_ch);
                        else n_pass++;
                    end
                end
            end
        join_none
        test_reset();
        test_single_job();
        test_fill_drain();
        test_preempt();
        test_bad_grant();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_total++; if (sb.size() != 0) $display("FAIL sb_left got %0d exp 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
